// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong score/match sequencing logic.
//   state_t  : match sequencer states (IDLE, SERVE, PLAY, OVER)
//   DIGIT_W  : width of one BCD digit
//   HIDE_X   : off-screen pos_x that makes a digit renderer draw nothing
//   to_bcd2  : converts a decimal integer 0..99 into two packed BCD digits
// ---------------------------------------------------------------------------
package pong_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [9:0] HIDE_X = 10'h3FF;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    // {tens, ones} of a decimal value; used to turn the integer winning
    // score parameter into the BCD pattern the counters produce.
    function automatic logic [2*DIGIT_W-1:0] to_bcd2(input int value);
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
        tens = DIGIT_W'(value / 10);
        ones = DIGIT_W'(value % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd_score_cnt.sv
// ---------------------------------------------------------------------------
// bcd_score_cnt
// Two-digit BCD goal counter for one player.
//   px_clk   in   pixel clock
//   reset    in   asynchronous active-high reset (clears to 00)
//   clr      in   synchronous clear to 00 (has priority over inc)
//   inc      in   add one to the score
//   tens     out  registered tens digit
//   ones     out  registered ones digit
//   tens_inc out  tens digit the counter would hold after an increment
//   ones_inc out  ones digit the counter would hold after an increment
// The *_inc outputs let the sequencer test the post-goal score against the
// winning score in the same cycle as the goal.
// ---------------------------------------------------------------------------
module bcd_score_cnt
    import pong_pkg::*;
(
    input  logic               px_clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic [DIGIT_W-1:0] tens_inc,
    output logic [DIGIT_W-1:0] ones_inc
);

    digit_t tens_reg;
    digit_t ones_reg;

    // Ones roll 9 -> 0 with a carry into tens. Tens never passes 9 because
    // the match ends at the winning score, which is at most 99.
    always_comb begin
        tens_inc = tens_reg;
        ones_inc = ones_reg + 1'b1;
        if (ones_reg == DIGIT_W'(9)) begin
            ones_inc = '0;
            tens_inc = tens_reg + 1'b1;
        end
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            tens_reg <= '0;
            ones_reg <= '0;
        end else if (clr) begin
            tens_reg <= '0;
            ones_reg <= '0;
        end else if (inc) begin
            tens_reg <= tens_inc;
            ones_reg <= ones_inc;
        end
    end

    assign tens = tens_reg;
    assign ones = ones_reg;

endmodule

// File: rtl/score_ctrl.sv
// ---------------------------------------------------------------------------
// score_ctrl
// Match and score sequencer for the pong stage. Counts goals per player in
// BCD, sequences serve / play / game-over from frame ticks and drives the
// number and pos_x inputs of four digit renderers (left tens, left ones,
// right tens, right ones). Digits are hidden by moving them off-screen.
//   px_clk      in   pixel clock
//   reset       in   asynchronous active-high reset
//   frame_tick  in   one-cycle pulse per frame
//   goal_l      in   left player scores (pulse)
//   goal_r      in   right player scores (pulse)
//   restart     in   clear scores and start a new match (pulse)
//   num_lt/lo/rt/ro  out  BCD digits for the renderers
//   px_lt/lo/rt/ro   out  pos_x for the renderers
//   serve_req   out  one-cycle pulse: launch the ball
//   serve_dir   out  0 = toward left, 1 = toward right
//   game_over   out  high while the match is over
//   winner      out  0 = left, 1 = right (meaningful while game_over)
// All outputs come straight from flip-flops.
// ---------------------------------------------------------------------------
module score_ctrl
    import pong_pkg::*;
#(
    parameter int         WIN_SCORE    = 11,
    parameter int         SERVE_FRAMES = 60,
    parameter int         BLINK_FRAMES = 30,
    parameter logic [9:0] X_L          = 10'd200,
    parameter logic [9:0] X_R          = 10'd400,
    parameter logic [9:0] PITCH        = 10'd40,
    parameter logic [9:0] HIDE_X       = pong_pkg::HIDE_X
) (
    input  logic               px_clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               goal_l,
    input  logic               goal_r,
    input  logic               restart,
    output logic [DIGIT_W-1:0] num_lt,
    output logic [DIGIT_W-1:0] num_lo,
    output logic [DIGIT_W-1:0] num_rt,
    output logic [DIGIT_W-1:0] num_ro,
    output logic [9:0]         px_lt,
    output logic [9:0]         px_lo,
    output logic [9:0]         px_rt,
    output logic [9:0]         px_ro,
    output logic               serve_req,
    output logic               serve_dir,
    output logic               game_over,
    output logic               winner
);

    localparam int CNT_MAX = (SERVE_FRAMES > BLINK_FRAMES) ? SERVE_FRAMES : BLINK_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // The counter holds ticks seen so far, so the Nth tick arrives while it
    // reads N-1.
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

    localparam logic [2*DIGIT_W-1:0] WIN_BCD = to_bcd2(WIN_SCORE);

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t           state_reg,     state_next;
    logic [CNT_W-1:0] cnt_reg,       cnt_next;
    logic             phase_reg,     phase_next;
    logic             dir_reg,       dir_next;
    logic             winner_reg,    winner_next;
    logic             serve_req_reg, serve_req_next;
    logic             game_over_reg;

    logic clr_scores;
    logic inc_l;
    logic inc_r;

    digit_t l_tens, l_ones, l_tens_inc, l_ones_inc;
    digit_t r_tens, r_ones, r_tens_inc, r_ones_inc;

    logic l_win;
    logic r_win;

    // ------------------------------------------------------------------
    // Per-player score counters
    // ------------------------------------------------------------------
    bcd_score_cnt u_score_l (
        .px_clk   (px_clk),
        .reset    (reset),
        .clr      (clr_scores),
        .inc      (inc_l),
        .tens     (l_tens),
        .ones     (l_ones),
        .tens_inc (l_tens_inc),
        .ones_inc (l_ones_inc)
    );

    bcd_score_cnt u_score_r (
        .px_clk   (px_clk),
        .reset    (reset),
        .clr      (clr_scores),
        .inc      (inc_r),
        .tens     (r_tens),
        .ones     (r_ones),
        .tens_inc (r_tens_inc),
        .ones_inc (r_ones_inc)
    );

    assign l_win = ({l_tens_inc, l_ones_inc} == WIN_BCD);
    assign r_win = ({r_tens_inc, r_ones_inc} == WIN_BCD);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        phase_next     = phase_reg;
        dir_next       = dir_reg;
        winner_next    = winner_reg;
        serve_req_next = 1'b0;
        clr_scores     = 1'b0;
        inc_l          = 1'b0;
        inc_r          = 1'b0;

        if (restart) begin
            // Restart wins over any goal arriving in the same cycle.
            clr_scores = 1'b1;
            dir_next   = 1'b1;
            cnt_next   = '0;
            phase_next = 1'b1;
            state_next = SERVE;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Shows 0 0 until the first restart.
                end

                SERVE: begin
                    // Goals are ignored while the ball is not in play.
                    if (frame_tick) begin
                        if (cnt_reg == SERVE_LAST) begin
                            serve_req_next = 1'b1;
                            state_next     = PLAY;
                            cnt_next       = '0;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                end

                PLAY: begin
                    if (goal_l && goal_r) begin
                        // Simultaneous goals cancel: re-serve, no score.
                        state_next = SERVE;
                        cnt_next   = '0;
                    end else if (goal_l || goal_r) begin
                        inc_l    = goal_l;
                        inc_r    = goal_r;
                        // Serve toward the player who conceded.
                        dir_next = goal_l;
                        cnt_next = '0;
                        if ((goal_l && l_win) || (goal_r && r_win)) begin
                            state_next  = OVER;
                            winner_next = goal_r;
                            phase_next  = 1'b1;
                        end else begin
                            state_next = SERVE;
                        end
                    end
                end

                OVER: begin
                    if (frame_tick) begin
                        if (cnt_reg == BLINK_LAST) begin
                            phase_next = ~phase_reg;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                end

                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            phase_reg     <= 1'b1;
            dir_reg       <= 1'b1;
            winner_reg    <= 1'b0;
            serve_req_reg <= 1'b0;
            game_over_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            phase_reg     <= phase_next;
            dir_reg       <= dir_next;
            winner_reg    <= winner_next;
            serve_req_reg <= serve_req_next;
            game_over_reg <= (state_next == OVER);
        end
    end

    // ------------------------------------------------------------------
    // Digit positions
    // pos_x is registered from the next-cycle digit values so that it
    // changes on the same edge as the digit it belongs to.
    // Index order: 0 left tens, 1 left ones, 2 right tens, 3 right ones.
    // ------------------------------------------------------------------
    digit_t     digit_next [4];
    logic [9:0] px_q       [4];

    always_comb begin
        digit_next[0] = l_tens;
        digit_next[1] = l_ones;
        digit_next[2] = r_tens;
        digit_next[3] = r_ones;
        if (clr_scores) begin
            for (int i = 0; i < 4; i++) begin
                digit_next[i] = '0;
            end
        end else begin
            if (inc_l) begin
                digit_next[0] = l_tens_inc;
                digit_next[1] = l_ones_inc;
            end
            if (inc_r) begin
                digit_next[2] = r_tens_inc;
                digit_next[3] = r_ones_inc;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pos
            localparam logic       IS_TENS = ((gi % 2) == 0);
            localparam logic       SIDE    = (gi >= 2);
            localparam logic [9:0] BASE_X  = ((gi < 2) ? X_L : X_R) + (IS_TENS ? 10'd0 : PITCH);
            // With both scores 0 the tens digits start out blanked.
            localparam logic [9:0] RST_X   = IS_TENS ? HIDE_X : BASE_X;

            logic [9:0] px_reg;
            logic [9:0] px_next;

            always_comb begin
                px_next = BASE_X;
                // Leading-zero blanking on the tens position.
                if (IS_TENS && (digit_next[gi] == '0)) begin
                    px_next = HIDE_X;
                end
                // Winner's digits blink off during the dark half of game-over.
                if ((state_next == OVER) && !phase_next && (winner_next == SIDE)) begin
                    px_next = HIDE_X;
                end
            end

            always_ff @(posedge px_clk or posedge reset) begin
                if (reset) begin
                    px_reg <= RST_X;
                end else begin
                    px_reg <= px_next;
                end
            end

            assign px_q[gi] = px_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign num_lt    = l_tens;
    assign num_lo    = l_ones;
    assign num_rt    = r_tens;
    assign num_ro    = r_ones;
    assign px_lt     = px_q[0];
    assign px_lo     = px_q[1];
    assign px_rt     = px_q[2];
    assign px_ro     = px_q[3];
    assign serve_req = serve_req_reg;
    assign serve_dir = dir_reg;
    assign game_over = game_over_reg;
    assign winner    = winner_reg;

endmodule

// File: tb/tb_score_ctrl.sv
// ---------------------------------------------------------------------------
// tb_score_ctrl
// Random goals, ticks, restarts and asynchronous resets are applied to
// score_ctrl; every cycle the outputs are compared with a reference model
// that tracks the match with plain integer scores and frame counts.
// ---------------------------------------------------------------------------
module tb_score_ctrl;

    localparam int         WIN = 11;
    localparam int         SF  = 60;
    localparam int         BF  = 30;
    localparam logic [9:0] XL  = 10'd200;
    localparam logic [9:0] XR  = 10'd400;
    localparam logic [9:0] PT  = 10'd40;
    localparam logic [9:0] HX  = 10'h3FF;

    localparam int M_IDLE  = 0;
    localparam int M_SERVE = 1;
    localparam int M_PLAY  = 2;
    localparam int M_OVER  = 3;

    localparam int N_CYCLES = 40000;

    logic       px_clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       goal_l = 1'b0;
    logic       goal_r = 1'b0;
    logic       restart = 1'b0;
    logic [3:0] num_lt, num_lo, num_rt, num_ro;
    logic [9:0] px_lt, px_lo, px_rt, px_ro;
    logic       serve_req, serve_dir, game_over, winner;

    always #5 px_clk = ~px_clk;

    score_ctrl #(
        .WIN_SCORE    (WIN),
        .SERVE_FRAMES (SF),
        .BLINK_FRAMES (BF),
        .X_L          (XL),
        .X_R          (XR),
        .PITCH        (PT),
        .HIDE_X       (HX)
    ) dut (
        .px_clk     (px_clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .goal_l     (goal_l),
        .goal_r     (goal_r),
        .restart    (restart),
        .num_lt     (num_lt),
        .num_lo     (num_lo),
        .num_rt     (num_rt),
        .num_ro     (num_ro),
        .px_lt      (px_lt),
        .px_lo      (px_lo),
        .px_rt      (px_rt),
        .px_ro      (px_ro),
        .serve_req  (serve_req),
        .serve_dir  (serve_dir),
        .game_over  (game_over),
        .winner     (winner)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: scores as integers, frames counted from 1.
    int m_st;
    int m_l;
    int m_r;
    int m_frames;
    bit m_phase;
    bit m_dir;
    bit m_win;
    bit m_sreq;
    int n_serves = 0;
    int n_overs  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st     = M_IDLE;
        m_l      = 0;
        m_r      = 0;
        m_frames = 0;
        m_phase  = 1'b1;
        m_dir    = 1'b1;
        m_win    = 1'b0;
        m_sreq   = 1'b0;
    endtask

    task automatic model_step(input bit rs, input bit gl, input bit gr, input bit tk);
        m_sreq = 1'b0;
        if (rs) begin
            m_l = 0;
            m_r = 0;
            m_dir = 1'b1;
            m_frames = 0;
            m_phase = 1'b1;
            m_st = M_SERVE;
            $display("[TB] cyc=%0d restart", cyc);
        end else if (m_st == M_SERVE) begin
            if (tk) begin
                m_frames++;
                if (m_frames == SF) begin
                    m_sreq = 1'b1;
                    m_st = M_PLAY;
                    m_frames = 0;
                    n_serves++;
                    $display("[TB] cyc=%0d serve dir=%0d score %0d:%0d", cyc, m_dir, m_l, m_r);
                end
            end
        end else if (m_st == M_PLAY) begin
            if (gl && gr) begin
                m_st = M_SERVE;
                m_frames = 0;
                $display("[TB] cyc=%0d double goal, no score", cyc);
            end else if (gl || gr) begin
                if (gl) m_l++;
                else    m_r++;
                m_dir = gl;
                m_frames = 0;
                if ((gl ? m_l : m_r) == WIN) begin
                    m_st = M_OVER;
                    m_win = gr;
                    m_phase = 1'b1;
                    n_overs++;
                    $display("[TB] cyc=%0d game over %0d:%0d winner=%0d", cyc, m_l, m_r, m_win);
                end else begin
                    m_st = M_SERVE;
                    $display("[TB] cyc=%0d goal %s -> %0d:%0d", cyc, gl ? "L" : "R", m_l, m_r);
                end
            end
        end else if (m_st == M_OVER) begin
            if (tk) begin
                m_frames++;
                if (m_frames == BF) begin
                    m_phase = ~m_phase;
                    m_frames = 0;
                end
            end
        end
    endtask

    function automatic logic [9:0] exp_px(input int idx);
        int         score;
        int         dig;
        logic [9:0] v;
        score = (idx < 2) ? m_l : m_r;
        dig   = ((idx % 2) == 0) ? (score / 10) : (score % 10);
        v     = ((idx < 2) ? XL : XR) + (((idx % 2) == 1) ? PT : 10'd0);
        if (((idx % 2) == 0) && (dig == 0)) v = HX;
        if ((m_st == M_OVER) && !m_phase && (m_win == (idx >= 2))) v = HX;
        return v;
    endfunction

    task automatic check_all();
        chk("num_lt", 32'(num_lt), 32'(m_l / 10));
        chk("num_lo", 32'(num_lo), 32'(m_l % 10));
        chk("num_rt", 32'(num_rt), 32'(m_r / 10));
        chk("num_ro", 32'(num_ro), 32'(m_r % 10));
        chk("px_lt", 32'(px_lt), 32'(exp_px(0)));
        chk("px_lo", 32'(px_lo), 32'(exp_px(1)));
        chk("px_rt", 32'(px_rt), 32'(exp_px(2)));
        chk("px_ro", 32'(px_ro), 32'(exp_px(3)));
        chk("serve_req", 32'(serve_req), 32'(m_sreq));
        chk("serve_dir", 32'(serve_dir), 32'(m_dir));
        chk("game_over", 32'(game_over), 32'(m_st == M_OVER));
        chk("winner", 32'(winner), 32'(m_win));
    endtask

    initial begin
        model_reset();
        #2 reset = 1'b1;
        #1 check_all();
        repeat (2) @(posedge px_clk);
        #1 check_all();
        @(negedge px_clk);
        reset = 1'b0;

        for (int i = 0; i < N_CYCLES; i++) begin
            @(negedge px_clk);
            cyc = i;
            if ($urandom_range(3999) == 0) begin
                // Asynchronous reset in the middle of a cycle.
                goal_l = 1'b0;
                goal_r = 1'b0;
                restart = 1'b0;
                frame_tick = 1'b0;
                #2 reset = 1'b1;
                #1;
                model_reset();
                $display("[TB] cyc=%0d async reset", cyc);
                check_all();
                @(posedge px_clk);
                #1 check_all();
                @(negedge px_clk);
                reset = 1'b0;
            end else begin
                if ((m_st == M_IDLE) || (m_st == M_OVER))
                    restart = ($urandom_range(149) == 0);
                else
                    restart = ($urandom_range(2999) == 0);
                goal_l     = ($urandom_range(9) == 0);
                goal_r     = ($urandom_range(9) == 0);
                frame_tick = ($urandom_range(1) == 0);
                @(posedge px_clk);
                model_step(restart, goal_l, goal_r, frame_tick);
                #1 check_all();
            end
        end

        $display("[TB] serves=%0d games_over=%0d", n_serves, n_overs);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/score_ctrl.md
Name: score_ctrl

Overview:
Match and score sequencer for the pong stage. It counts goals per player as 2-digit BCD and runs serve, play and game-over sequencing from frame ticks. It drives the number and pos_x inputs of four digit renderer instances: left tens, left ones, right tens and right ones. Digits are hidden by steering pos_x off-screen, since the renderer has no enable input. It sits between the ball/collision logic (goal pulses, serve request) and the digit chain in the RGB stream.

Parameters:
WIN_SCORE, 11, BCD-interpreted winning score, 1..99
SERVE_FRAMES, 60, frame ticks between a point or restart and serve_req
BLINK_FRAMES, 30, frame ticks per blink half-period in game-over
X_L, 10'd200, pos_x of the left tens digit
X_R, 10'd400, pos_x of the right tens digit
PITCH, 10'd40, x offset from a tens digit to its ones digit
HIDE_X, 10'h3FF, off-screen pos_x that suppresses a digit

Ports:
px_clk  in  1  pixel clock, the only clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame (start of vsync)
goal_l  in  1  one-cycle pulse: left player scores
goal_r  in  1  one-cycle pulse: right player scores
restart  in  1  one-cycle pulse: clear scores and begin a new match
num_lt, num_lo, num_rt, num_ro  out  4 each  BCD digits for the four renderers
px_lt, px_lo, px_rt, px_ro  out  10 each  pos_x for the four renderers
serve_req  out  1  one-cycle pulse: launch the ball
serve_dir  out  1  0 = serve toward left, 1 = serve toward right
game_over  out  1  high while in OVER
winner  out  1  0 = left, 1 = right; valid while game_over

Behaviour:
- States: IDLE, SERVE, PLAY, OVER. On reset: IDLE, all scores 0, serve_req=0, serve_dir=1, game_over=0, winner=0, blink phase=1, frame counter=0. All outputs are registered.
- IDLE: displays 0 0 and waits. restart -> SERVE.
- restart in any state: scores cleared, serve_dir=1, frame counter cleared, next state SERVE. restart has priority over a goal in the same cycle.
- SERVE: count frame_tick. On the SERVE_FRAMES-th tick, pulse serve_req for exactly one cycle and move to PLAY in the same edge. Goals in SERVE are ignored.
- PLAY, single goal: on the next edge the scorer's BCD increments. Ones 9 -> 0 with tens+1; no wrap beyond 99 is possible because WIN_SCORE <= 99. serve_dir points toward the player who conceded (goal_l -> 1, goal_r -> 0).
- PLAY, after scoring: if the new score equals WIN_SCORE, go to OVER with winner=scorer. Otherwise go to SERVE with the frame counter cleared.
- PLAY, goal_l and goal_r in the same cycle: no score change, serve_dir unchanged, go to SERVE.
- Score latency: num_* reflect the goal 1 cycle after the goal pulse.
- OVER: goals are ignored, game_over=1. Every BLINK_FRAMES ticks the blink phase toggles. While phase=0, both of the winner's px_* = HIDE_X. Only restart leaves OVER.
- pos_x rule: px_lt = X_L, px_lo = X_L+PITCH, px_rt = X_R, px_ro = X_R+PITCH, subject to two overrides. First, leading-zero blanking: a tens digit equal to 0 gets HIDE_X. Second, blink hiding applies in OVER as above.
- Frame counter width: clog2 of max(SERVE_FRAMES, BLINK_FRAMES)+1. The counter is cleared on every state change.
- Reset asserted mid-match returns everything to the reset values asynchronously.

Decomposition:
- Shared package pong_pkg holds the state encoding (IDLE/SERVE/PLAY/OVER), HIDE_X, and the BCD digit width constant.
- One natural sub-module, bcd_score_cnt: a 2-digit BCD counter with clear, inc and a tens/ones output. It is instantiated twice, once per player.

Test Plan:
1. Reset, then restart; 60 frame_ticks -> serve_req pulses once on tick 60; serve_dir=1; num_* = 0; px_lt = px_rt = 3FF; px_lo = 240; px_ro = 440.
2. In PLAY, goal_l 10 times (each followed by a serve) -> num_lt=1, num_lo=0, px_lt=200, serve_dir=1 after each.
3. goal_l and goal_r in the same cycle in PLAY -> scores unchanged, state goes to SERVE, serve_req after 60 ticks.
4. Right player reaches 11 -> game_over=1, winner=1. After 30 ticks px_rt = px_ro = 3FF; after 60 ticks they are restored. A goal_r in OVER leaves num_ro unchanged.
5. goal_r pulse during SERVE -> ignored, no score change.
6. Reset asserted mid-PLAY with left=7 -> immediate IDLE, all num_* = 0, serve_req stays 0.
